// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 constants (iCodes, stat codes, register IDs) and writeback dst decode helpers.
package y86_pkg;
    typedef enum logic [3:0] {
        HALT = 4'h0, NOP = 4'h1, RRMOVQ = 4'h2, IRMOVQ = 4'h3,
        RMMOVQ = 4'h4, MRMOVQ = 4'h5, OPQ = 4'h6, JXX = 4'h7,
        CALL = 4'h8, RET = 4'h9, PUSHQ = 4'hA, POPQ = 4'hB
    } icode_t;
    typedef enum logic {RUN, HALTED} halt_state_t;
    localparam logic [2:0] STAT_BUB = 3'd0;
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;
    localparam logic [3:0] RSP = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    function automatic logic [3:0] raw_dst_e(input logic [3:0] icode, input logic [3:0] rb, input logic cnd);
        case (icode)
            RRMOVQ: return cnd ? rb : RNONE;
            IRMOVQ, OPQ: return rb;
            CALL, RET, PUSHQ, POPQ: return RSP;
            default: return RNONE;
        endcase
    endfunction

    function automatic logic [3:0] raw_dst_m(input logic [3:0] icode, input logic [3:0] ra);
        return (icode == MRMOVQ || icode == POPQ) ? ra : RNONE;
    endfunction
endpackage

// File: rtl/regfile_15x64.sv
// regfile_15x64: 15x64 register array, two write ports (M wins on collision), two write-through read ports.
module regfile_15x64 import y86_pkg::*; #(
    parameter logic [63:0] RSP_RESET = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  dst_e,
    input  logic [3:0]  dst_m,
    input  logic [63:0] val_e,
    input  logic [63:0] val_m,
    input  logic [3:0]  src_a,
    input  logic [3:0]  src_b,
    output logic [63:0] rval_a,
    output logic [63:0] rval_b
);
    logic [63:0] regs [15];

    for (genvar r = 0; r < 15; r++) begin : g_reg
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                regs[r] <= (r == int'(RSP)) ? RSP_RESET : 64'h0;
            else if (dst_m == 4'(r))
                regs[r] <= val_m;
            else if (dst_e == 4'(r))
                regs[r] <= val_e;
        end
    end

    // Bypass order mirrors write priority so a read always sees the value about to commit.
    function automatic logic [63:0] rd(input logic [3:0] src);
        return (src == RNONE) ? 64'h0 :
               (src == dst_m) ? val_m :
               (src == dst_e) ? val_e : regs[src];
    endfunction

    always_comb begin
        rval_a = rd(src_a);
        rval_b = rd(src_b);
    end
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: Y86-64 writeback stage -- dst decode, commit gating, halt FSM, retired counter, register file.
module wb_regfile import y86_pkg::*; #(
    parameter logic [63:0] RSP_RESET = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  W_stat,
    input  logic [3:0]  W_iCode,
    input  logic [3:0]  W_rA,
    input  logic [3:0]  W_rB,
    input  logic        W_Cnd,
    input  logic [63:0] W_valE,
    input  logic [63:0] W_valM,
    input  logic [3:0]  d_srcA,
    input  logic [3:0]  d_srcB,
    output logic [63:0] d_rvalA,
    output logic [63:0] d_rvalB,
    output logic [3:0]  w_dstE,
    output logic [3:0]  w_dstM,
    output logic [63:0] w_valE,
    output logic [63:0] w_valM,
    output logic [2:0]  stat,
    output logic        halted,
    output logic [63:0] retired
);
    halt_state_t state_q, state_d;
    logic [2:0] halt_stat;
    logic faulting, commit;

    always_comb begin
        faulting = W_stat == STAT_HLT || W_stat == STAT_ADR || W_stat == STAT_INS;
        commit = !rst && W_stat == STAT_AOK && state_q == RUN;
        state_d = (state_q == RUN && faulting) ? HALTED : state_q;
        halted = state_q == HALTED;
        w_dstE = commit ? raw_dst_e(W_iCode, W_rB, W_Cnd) : RNONE;
        w_dstM = commit ? raw_dst_m(W_iCode, W_rA) : RNONE;
        w_valE = W_valE;
        w_valM = W_valM;
        stat = rst ? STAT_AOK : halted ? halt_stat : (W_stat == STAT_BUB) ? STAT_AOK : W_stat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            halt_stat <= STAT_AOK;
            retired <= 64'h0;
        end else begin
            state_q <= state_d;
            if (state_q == RUN && faulting)
                halt_stat <= W_stat;
            if (commit)
                retired <= retired + 64'd1;
        end
    end

    regfile_15x64 #(.RSP_RESET(RSP_RESET)) u_rf (
        .clk(clk),
        .rst(rst),
        .dst_e(w_dstE),
        .dst_m(w_dstM),
        .val_e(W_valE),
        .val_m(W_valM),
        .src_a(d_srcA),
        .src_b(d_srcB),
        .rval_a(d_rvalA),
        .rval_b(d_rvalB)
    );
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed vector table, reset sequence, and randomized run against a behavioural model.
module tb_wb_regfile;
    logic clk = 1'b0;
    logic rst;
    logic [2:0] W_stat;
    logic [3:0] W_iCode, W_rA, W_rB, d_srcA, d_srcB;
    logic W_Cnd;
    logic [63:0] W_valE, W_valM;
    logic [63:0] d_rvalA, d_rvalB, w_valE, w_valM, retired;
    logic [3:0] w_dstE, w_dstM;
    logic [2:0] stat;
    logic halted;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    wb_regfile #(.RSP_RESET(64'h200)) dut (
        .clk(clk), .rst(rst), .W_stat(W_stat), .W_iCode(W_iCode), .W_rA(W_rA), .W_rB(W_rB),
        .W_Cnd(W_Cnd), .W_valE(W_valE), .W_valM(W_valM), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .d_rvalA(d_rvalA), .d_rvalB(d_rvalB), .w_dstE(w_dstE), .w_dstM(w_dstM),
        .w_valE(w_valE), .w_valM(w_valM), .stat(stat), .halted(halted), .retired(retired)
    );

    typedef struct {
        logic [2:0] st; logic [3:0] ic, ra, rb; logic cnd; logic [63:0] ve, vm; logic [3:0] sa, sb;
        logic [3:0] xe, xm; logic [63:0] xa, xb; logic [2:0] xs; logic xh; logic [63:0] xr;
    } vec_t;
    vec_t tv[10];

    // Behavioural model: architectural state only.
    logic [63:0] m_regs [15];
    logic m_halted;
    logic [2:0] m_hstat;
    logic [63:0] m_retired;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] st, input logic [3:0] ic, ra, rb, input logic cnd,
                         input logic [63:0] ve, vm, input logic [3:0] sa, sb);
        W_stat = st; W_iCode = ic; W_rA = ra; W_rB = rb; W_Cnd = cnd;
        W_valE = ve; W_valM = vm; d_srcA = sa; d_srcB = sb;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 15; i++) m_regs[i] = (i == 4) ? 64'h200 : 64'h0;
        m_halted = 1'b0; m_hstat = 3'd1; m_retired = 64'h0;
    endtask

    function automatic logic [3:0] exp_dst_e(input logic [3:0] ic, rb, input logic cnd);
        if ((ic == 4'h2 && cnd) || ic == 4'h3 || ic == 4'h6) return rb;
        if (ic >= 4'h8 && ic <= 4'hB) return 4'h4;
        return 4'hF;
    endfunction

    task automatic random_cycle();
        logic [2:0] st;
        logic [3:0] ic, ra, rb, sa, sb, xe, xm;
        logic cnd, ok;
        logic [63:0] ve, vm;
        logic [63:0] nxt [15];
        int r;
        r = $urandom_range(0, 99);
        st = r < 80 ? 3'd1 : r < 88 ? 3'd0 : r < 94 ? 3'(5 + $urandom_range(0, 2)) : 3'(2 + $urandom_range(0, 2));
        ic = 4'($urandom_range(0, 15)); ra = 4'($urandom_range(0, 15)); rb = 4'($urandom_range(0, 15));
        cnd = 1'($urandom_range(0, 1)); ve = {$urandom, $urandom}; vm = {$urandom, $urandom};
        sa = 4'($urandom_range(0, 15)); sb = 4'($urandom_range(0, 15));
        drive(st, ic, ra, rb, cnd, ve, vm, sa, sb);
        ok = st == 3'd1 && !m_halted;
        xe = ok ? exp_dst_e(ic, rb, cnd) : 4'hF;
        xm = (ok && (ic == 4'h5 || ic == 4'hB)) ? ra : 4'hF;
        nxt = m_regs;
        if (xe != 4'hF) nxt[xe] = ve;
        if (xm != 4'hF) nxt[xm] = vm;
        @(negedge clk);
        chk("rnd_dstE", 64'(w_dstE), 64'(xe));
        chk("rnd_dstM", 64'(w_dstM), 64'(xm));
        chk("rnd_rvalA", d_rvalA, sa == 4'hF ? 64'h0 : nxt[sa]);
        chk("rnd_rvalB", d_rvalB, sb == 4'hF ? 64'h0 : nxt[sb]);
        chk("rnd_valE", w_valE, ve);
        chk("rnd_valM", w_valM, vm);
        chk("rnd_stat", 64'(stat), 64'(m_halted ? m_hstat : (st == 3'd0 ? 3'd1 : st)));
        chk("rnd_halted", 64'(halted), 64'(m_halted));
        chk("rnd_retired", retired, m_retired);
        @(posedge clk);
        #1;
        if (ok) begin
            m_regs = nxt;
            m_retired++;
        end
        if (!m_halted && st >= 3'd2 && st <= 3'd4) begin
            m_halted = 1'b1;
            m_hstat = st;
        end
    endtask

    initial begin
        tv[0] = '{3'd0, 4'h1, 4'h0, 4'h0, 1'b0, 64'h0,   64'h0,  4'h4, 4'h0, 4'hF, 4'hF, 64'h200, 64'h0,   3'd1, 1'b0, 64'd0};
        tv[1] = '{3'd1, 4'h3, 4'h0, 4'h2, 1'b0, 64'h55,  64'h0,  4'h2, 4'h4, 4'h2, 4'hF, 64'h55,  64'h200, 3'd1, 1'b0, 64'd0};
        tv[2] = '{3'd1, 4'h1, 4'h0, 4'h0, 1'b0, 64'h0,   64'h0,  4'h2, 4'h3, 4'hF, 4'hF, 64'h55,  64'h0,   3'd1, 1'b0, 64'd1};
        tv[3] = '{3'd1, 4'h2, 4'h0, 4'h3, 1'b0, 64'h7,   64'h0,  4'h3, 4'h2, 4'hF, 4'hF, 64'h0,   64'h55,  3'd1, 1'b0, 64'd2};
        tv[4] = '{3'd1, 4'h2, 4'h0, 4'h3, 1'b1, 64'h7,   64'h0,  4'h3, 4'hF, 4'h3, 4'hF, 64'h7,   64'h0,   3'd1, 1'b0, 64'd3};
        tv[5] = '{3'd1, 4'hB, 4'h4, 4'h0, 1'b0, 64'h108, 64'hAA, 4'h4, 4'h3, 4'h4, 4'h4, 64'hAA,  64'h7,   3'd1, 1'b0, 64'd4};
        tv[6] = '{3'd1, 4'h1, 4'h0, 4'h0, 1'b0, 64'h0,   64'h0,  4'h4, 4'h2, 4'hF, 4'hF, 64'hAA,  64'h55,  3'd1, 1'b0, 64'd5};
        tv[7] = '{3'd3, 4'h5, 4'h1, 4'h0, 1'b0, 64'h0,   64'h99, 4'h1, 4'hF, 4'hF, 4'hF, 64'h0,   64'h0,   3'd3, 1'b0, 64'd6};
        tv[8] = '{3'd1, 4'h3, 4'h0, 4'h1, 1'b0, 64'h77,  64'h0,  4'h1, 4'hF, 4'hF, 4'hF, 64'h0,   64'h0,   3'd3, 1'b1, 64'd6};
        tv[9] = '{3'd1, 4'h1, 4'h0, 4'h0, 1'b0, 64'h0,   64'h0,  4'h1, 4'h4, 4'hF, 4'hF, 64'h0,   64'hAA,  3'd3, 1'b1, 64'd6};
        rst = 1'b1;
        drive(3'd0, 4'h1, 4'h0, 4'h0, 1'b0, 64'h0, 64'h0, 4'hF, 4'hF);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(tv[i].st, tv[i].ic, tv[i].ra, tv[i].rb, tv[i].cnd, tv[i].ve, tv[i].vm, tv[i].sa, tv[i].sb);
            @(negedge clk);
            chk($sformatf("v%0d_dstE", i), 64'(w_dstE), 64'(tv[i].xe));
            chk($sformatf("v%0d_dstM", i), 64'(w_dstM), 64'(tv[i].xm));
            chk($sformatf("v%0d_rvalA", i), d_rvalA, tv[i].xa);
            chk($sformatf("v%0d_rvalB", i), d_rvalB, tv[i].xb);
            chk($sformatf("v%0d_stat", i), 64'(stat), 64'(tv[i].xs));
            chk($sformatf("v%0d_halted", i), 64'(halted), 64'(tv[i].xh));
            chk($sformatf("v%0d_retired", i), retired, tv[i].xr);
            @(posedge clk);
            #1;
        end
        // Reset while halted, with a committable irmovq held across the reset edge.
        drive(3'd1, 4'h3, 4'h0, 4'h2, 1'b0, 64'h1234, 64'h0, 4'h4, 4'h2);
        rst = 1'b1;
        #1;
        chk("rst_halted", 64'(halted), 64'h0);
        chk("rst_stat", 64'(stat), 64'h1);
        chk("rst_retired", retired, 64'h0);
        chk("rst_dstE", 64'(w_dstE), 64'hF);
        chk("rst_rvalA", d_rvalA, 64'h200);
        chk("rst_rvalB", d_rvalB, 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        drive(3'd0, 4'h1, 4'h0, 4'h0, 1'b0, 64'h0, 64'h0, 4'h2, 4'h3);
        @(negedge clk);
        chk("post_rst_r2", d_rvalA, 64'h0);
        chk("post_rst_r3", d_rvalB, 64'h0);
        d_srcA = 4'h1; d_srcB = 4'h4;
        #1;
        chk("post_rst_r1", d_rvalA, 64'h0);
        chk("post_rst_r4", d_rvalB, 64'h200);
        chk("post_rst_retired", retired, 64'h0);
        // Randomized blocks, each opened by a reset so faults do not freeze the run.
        for (int b = 0; b < 6; b++) begin
            @(posedge clk);
            rst = 1'b1;
            drive(3'd0, 4'h1, 4'h0, 4'h0, 1'b0, 64'h0, 64'h0, 4'hF, 4'hF);
            #1 rst = 1'b0;
            model_reset();
            for (int c = 0; c < 60; c++) random_cycle();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
